// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: bus widths, state encodings and shared types for the WB stage.
`ifndef WB_DEFINES_V
`define WB_DEFINES_V
`define MEM_TO_WB_BUS_WIDTH 38
`define WB_TO_ID_BUS_WIDTH 39
`define WB_ST_RUN 2'd0
`define WB_ST_HALTED 2'd1
`define WB_ST_STEP 2'd2
`endif

package wb_stage_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = `WB_ST_RUN,
    ST_HALTED = `WB_ST_HALTED,
    ST_STEP   = `WB_ST_STEP
  } wb_state_e;
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
  } wb_bus_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB valid/allow_in handshake and payload bus.
interface wb_stage_if;
  logic [`MEM_TO_WB_BUS_WIDTH-1:0] mem_to_wb_bus;
  logic                            mem_to_wb_valid;
  logic                            wb_allow_in;
  modport master(output mem_to_wb_bus, mem_to_wb_valid, input wb_allow_in);
  modport slave(input mem_to_wb_bus, mem_to_wb_valid, output wb_allow_in);
endinterface

// File: rtl/wb_retire_cnt.sv
// wb_retire_cnt: 64-bit wrapping retired-instruction counter; exists only with WB_INSTRET_EN.
`ifdef WB_INSTRET_EN
module wb_retire_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [63:0] cnt
);
  logic [63:0] cnt_q, cnt_d;
  always_comb cnt_d = inc ? cnt_q + 64'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule
`endif

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage with debug halt/step/resume control.
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  wb_stage_if.slave                      mem,
  input  logic                           halt_req,
  input  logic                           step_req,
  input  logic                           resume_req,
  output logic                           halted,
  output logic                           rf_we,
  output logic [4:0]                     rf_waddr,
  output logic [31:0]                    rf_wdata,
  output logic [`WB_TO_ID_BUS_WIDTH-1:0] wb_to_id_bus
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]                    instret
`endif
);
  wb_state_e state_q, state_d;
  logic      halted_q, halted_d;
  logic      wb_valid_q, wb_valid_d;
  wb_bus_t   wb_regs_q, wb_regs_d;
  logic      ready_go, retire, accept;
  assign ready_go = state_q != ST_HALTED;
  assign mem.wb_allow_in = !wb_valid_q || ready_go;
  assign retire = wb_valid_q && ready_go;
  assign accept = mem.wb_allow_in && mem.mem_to_wb_valid;
  always_comb begin
    wb_valid_d = mem.wb_allow_in ? mem.mem_to_wb_valid : wb_valid_q;
    wb_regs_d  = accept ? wb_bus_t'(mem.mem_to_wb_bus) : wb_regs_q;
    // resume beats step; a STEP cycle always falls back to HALTED
    state_d = state_q == ST_RUN    ? (halt_req ? ST_HALTED : ST_RUN) :
              state_q == ST_HALTED ? (resume_req ? ST_RUN : step_req ? ST_STEP : ST_HALTED) :
              ST_HALTED;
    halted_d = state_d == ST_HALTED;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= ST_RUN;
      halted_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_regs_q  <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      wb_valid_q <= wb_valid_d;
      wb_regs_q  <= wb_regs_d;
    end
  assign halted       = halted_q;
  assign rf_we        = retire && wb_regs_q.rf_we && (wb_regs_q.wb_reg != 5'd0);
  assign rf_waddr     = wb_regs_q.wb_reg;
  assign rf_wdata     = wb_regs_q.wb_data;
  assign wb_to_id_bus = {wb_valid_q, wb_regs_q};
`ifdef WB_INSTRET_EN
  wb_retire_cnt u_cnt (.clk(clk), .rst(rst), .inc(retire), .cnt(instret));
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table, reset/wrap sequences and a randomized run against a behavioural model.
module tb_wb_stage;
  import wb_stage_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req, step_req, resume_req;
  logic        halted, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [38:0] wb_to_id_bus;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif
  wb_stage_if bus_if();
  wb_stage dut (
    .clk(clk), .rst(rst), .mem(bus_if), .halt_req(halt_req), .step_req(step_req),
    .resume_req(resume_req), .halted(halted), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wb_to_id_bus(wb_to_id_bus)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [37:0] bus;
    logic [2:0]  hsr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hl;
    logic        al;
    logic [38:0] byp;
    longint      ret;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [37:0] bus, input logic [2:0] hsr,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic hl, input logic al, input logic byv, input longint ret);
    vec_t t;
    t.v = v; t.bus = bus; t.hsr = hsr; t.we = we; t.wa = wa; t.wd = wd;
    t.hl = hl; t.al = al; t.byp = {byv, 1'b1, wa, wd}; t.ret = ret;
    return t;
  endfunction

  // Behavioural model: debug mode, the instruction held in WB, and retire count
  int          m_mode;
  bit          m_v;
  wb_bus_t     m_r;
  longint unsigned m_cnt;

  task automatic model_reset();
    m_mode = 0; m_v = 0; m_r = '0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input wb_bus_t b, input bit h, input bit s, input bit r);
    bit ready, allow;
    ready = (m_mode != 1);
    allow = !m_v || ready;
    if (m_v && ready) m_cnt++;
    if (allow && v) m_r = b;
    if (allow) m_v = v;
    if (m_mode == 0) m_mode = h ? 1 : 0;
    else if (m_mode == 1) m_mode = r ? 0 : (s ? 2 : 1);
    else m_mode = 1;
  endtask

  task automatic model_check(input string tag);
    bit ready;
    ready = (m_mode != 1);
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(m_v && ready && m_r.rf_we && m_r.wb_reg != 0));
    chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(m_r.wb_reg));
    chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(m_r.wb_data));
    chk({tag, ".halted"}, 64'(halted), 64'(m_mode == 1));
    chk({tag, ".allow_in"}, 64'(bus_if.wb_allow_in), 64'(!m_v || ready));
    chk({tag, ".bypass"}, 64'(wb_to_id_bus), 64'({m_v, m_r}));
`ifdef WB_INSTRET_EN
    chk({tag, ".instret"}, instret, m_cnt);
`endif
  endtask

  task automatic drive(input logic v, input logic [37:0] b, input logic [2:0] hsr);
    bus_if.mem_to_wb_valid = v;
    bus_if.mem_to_wb_bus = b;
    {halt_req, step_req, resume_req} = hsr;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 38'd0, 3'b000);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = mk(1'b1, {1'b1, 5'd3, 32'hDEADBEEF}, 3'b000, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 0);
    vt[1]  = mk(1'b1, {1'b1, 5'd0, 32'h1234}, 3'b000, 1'b0, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b1, 1);
    vt[2]  = mk(1'b0, 38'd0, 3'b100, 1'b0, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0, 2);
    vt[3]  = mk(1'b1, {1'b1, 5'd7, 32'h55}, 3'b000, 1'b0, 5'd7, 32'h55, 1'b1, 1'b0, 1'b1, 2);
    vt[4]  = mk(1'b1, {1'b1, 5'd9, 32'h99}, 3'b000, 1'b0, 5'd7, 32'h55, 1'b1, 1'b0, 1'b1, 2);
    vt[5]  = mk(1'b0, 38'd0, 3'b001, 1'b1, 5'd7, 32'h55, 1'b0, 1'b1, 1'b1, 2);
    vt[6]  = mk(1'b0, 38'd0, 3'b000, 1'b0, 5'd7, 32'h55, 1'b0, 1'b1, 1'b0, 3);
    vt[7]  = mk(1'b0, 38'd0, 3'b100, 1'b0, 5'd7, 32'h55, 1'b1, 1'b1, 1'b0, 3);
    vt[8]  = mk(1'b1, {1'b1, 5'd4, 32'h44}, 3'b011, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1, 3);
    vt[9]  = mk(1'b1, {1'b1, 5'd5, 32'h50}, 3'b100, 1'b0, 5'd5, 32'h50, 1'b1, 1'b0, 1'b1, 4);
    vt[10] = mk(1'b1, {1'b1, 5'd6, 32'h60}, 3'b010, 1'b1, 5'd5, 32'h50, 1'b0, 1'b1, 1'b1, 4);
    vt[11] = mk(1'b1, {1'b1, 5'd6, 32'h60}, 3'b000, 1'b0, 5'd6, 32'h60, 1'b1, 1'b0, 1'b1, 5);
    vt[12] = mk(1'b0, 38'd0, 3'b000, 1'b0, 5'd6, 32'h60, 1'b1, 1'b0, 1'b1, 5);

    rst = 1'b1;
    drive(1'b0, 38'd0, 3'b000);
    cycle();
    chk("reset.rf_we", 64'(rf_we), 64'd0);
    chk("reset.halted", 64'(halted), 64'd0);
    chk("reset.allow_in", 64'(bus_if.wb_allow_in), 64'd1);
    chk("reset.bypass", 64'(wb_to_id_bus), 64'd0);
`ifdef WB_INSTRET_EN
    chk("reset.instret", instret, 64'd0);
`endif
    cycle();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v, vt[i].bus, vt[i].hsr);
      cycle();
      chk($sformatf("vec%0d.rf_we", i), 64'(rf_we), 64'(vt[i].we));
      chk($sformatf("vec%0d.rf_waddr", i), 64'(rf_waddr), 64'(vt[i].wa));
      chk($sformatf("vec%0d.rf_wdata", i), 64'(rf_wdata), 64'(vt[i].wd));
      chk($sformatf("vec%0d.halted", i), 64'(halted), 64'(vt[i].hl));
      chk($sformatf("vec%0d.allow_in", i), 64'(bus_if.wb_allow_in), 64'(vt[i].al));
      chk($sformatf("vec%0d.bypass", i), 64'(wb_to_id_bus), 64'(vt[i].byp));
`ifdef WB_INSTRET_EN
      chk($sformatf("vec%0d.instret", i), instret, 64'(vt[i].ret));
`endif
    end

    // Async reset mid-cycle while HALTED holding a valid write to x6
    drive(1'b0, 38'd0, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.rf_we", 64'(rf_we), 64'd0);
    chk("midrst.halted", 64'(halted), 64'd0);
    chk("midrst.allow_in", 64'(bus_if.wb_allow_in), 64'd1);
    chk("midrst.bypass", 64'(wb_to_id_bus), 64'd0);
`ifdef WB_INSTRET_EN
    chk("midrst.instret", instret, 64'd0);
`endif
    cycle();
    rst = 1'b0;
    cycle();
    chk("postrst.rf_we", 64'(rf_we), 64'd0);
    chk("postrst.halted", 64'(halted), 64'd0);

`ifdef WB_INSTRET_EN
    do_reset();
    drive(1'b1, {1'b1, 5'd2, 32'hABC}, 3'b000);
    cycle();
    force dut.u_cnt.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_cnt.cnt_q;
    drive(1'b0, 38'd0, 3'b000);
    cycle();
    chk("wrap.instret", instret, 64'd0);
`endif

    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      wb_bus_t b;
      bit v, h, s, r;
      v = $urandom_range(0, 9) < 6;
      b.rf_we = 1'($urandom_range(0, 1));
      b.wb_reg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      b.wb_data = $urandom;
      h = $urandom_range(0, 9) == 0;
      s = $urandom_range(0, 6) == 0;
      r = $urandom_range(0, 6) == 0;
      drive(v, b, {h, s, r});
      model_edge(v, b, h, s, r);
      cycle();
      model_check($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
